// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle controller.
// Holds the opcode map, ALU function and immediate-extension encodings, the
// 4-bit FSM state encoding, the control-word struct, and small opcode
// classification helpers used by both the FSM and the output decoder.
package multicycle_control_pkg;

  localparam int OPC_W_DEF  = 6;
  localparam int FUNC_W_DEF = 6;

  // Opcode map (Instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'b100000;
  localparam logic [5:0] OPC_LI    = 6'b111000;
  localparam logic [5:0] OPC_LUI   = 6'b111001;
  localparam logic [5:0] OPC_ADDI  = 6'b110000;
  localparam logic [5:0] OPC_ANDI  = 6'b110010;
  localparam logic [5:0] OPC_ORI   = 6'b110011;
  localparam logic [5:0] OPC_B     = 6'b111111;
  localparam logic [5:0] OPC_BEQ   = 6'b000000;
  localparam logic [5:0] OPC_BNE   = 6'b000001;
  localparam logic [5:0] OPC_LB    = 6'b000011;
  localparam logic [5:0] OPC_LW    = 6'b001111;
  localparam logic [5:0] OPC_SB    = 6'b000111;
  localparam logic [5:0] OPC_SW    = 6'b011111;

  // ALU function encodings
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Immediate extension modes
  localparam logic [1:0] IMM_SEXT     = 2'b00;
  localparam logic [1:0] IMM_ZFILL    = 2'b01;
  localparam logic [1:0] IMM_HI16     = 2'b10;
  localparam logic [1:0] IMM_SEXT_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_IFETCH   = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_R     = 3'd0,
    CLS_ALUI  = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_CBR   = 3'd4,
    CLS_JUMP  = 3'd5,
    CLS_BAD   = 3'd6
  } opc_class_t;

  typedef struct packed {
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_sel;
    logic       rf_wr;
    logic       rf_wrdata_sel;
    logic       rf_b_sel;
    logic [1:0] imm_ext;
    logic       alu_bin_sel;
    logic [3:0] alu_func;
    logic       mem_req;
    logic       mem_wr;
    logic       byte_op;
    logic       illegal;
  } ctrl_t;

  // Group an opcode into the instruction class that picks the FSM path.
  function automatic opc_class_t opc_class(input logic [5:0] opc);
    opc_class_t cls;
    case (opc)
      OPC_RTYPE:                                  cls = CLS_R;
      OPC_LI, OPC_LUI, OPC_ADDI, OPC_ANDI, OPC_ORI: cls = CLS_ALUI;
      OPC_LB, OPC_LW:                             cls = CLS_LOAD;
      OPC_SB, OPC_SW:                             cls = CLS_STORE;
      OPC_BEQ, OPC_BNE:                           cls = CLS_CBR;
      OPC_B:                                      cls = CLS_JUMP;
      default:                                    cls = CLS_BAD;
    endcase
    return cls;
  endfunction

  // Immediate extension mode implied by the opcode.
  function automatic logic [1:0] imm_ext_for(input logic [5:0] opc);
    logic [1:0] mode;
    case (opc)
      OPC_ANDI, OPC_ORI:         mode = IMM_ZFILL;
      OPC_LUI:                   mode = IMM_HI16;
      OPC_B, OPC_BEQ, OPC_BNE:   mode = IMM_SEXT_SH2;
      default:                   mode = IMM_SEXT;
    endcase
    return mode;
  endfunction

  // RF_B reads Instr[20:16] for immediate ALU ops, stores and compares.
  function automatic logic rf_b_sel_for(input logic [5:0] opc);
    logic sel;
    case (opc)
      OPC_LI, OPC_LUI, OPC_ADDI, OPC_ANDI, OPC_ORI,
      OPC_SB, OPC_SW, OPC_BEQ, OPC_BNE: sel = 1'b1;
      default:                          sel = 1'b0;
    endcase
    return sel;
  endfunction

  // Byte-wide memory access.
  function automatic logic is_byte_op(input logic [5:0] opc);
    return (opc == OPC_LB) || (opc == OPC_SB);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle controller and the datapath.
// master: controller side (consumes Instr/ALU_zero/Mem_Ready, drives strobes).
// slave : datapath side (the mirror image).
interface multicycle_control_if;

  logic [31:0] Instr;
  logic        ALU_zero;
  logic        Mem_Ready;

  logic        IR_LdEn;
  logic        PC_LdEn;
  logic        PC_sel;
  logic        RF_WrEn;
  logic        RF_WrData_sel;
  logic        RF_B_sel;
  logic [1:0]  ImmExt;
  logic        ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        MEM_Req;
  logic        MEM_WrEn;
  logic        ByteOp;
  logic        Illegal;

  modport master (
    input  Instr, ALU_zero, Mem_Ready,
    output IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ImmExt, ALU_Bin_sel, ALU_func, MEM_Req, MEM_WrEn, ByteOp, Illegal
  );

  modport slave (
    output Instr, ALU_zero, Mem_Ready,
    input  IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ImmExt, ALU_Bin_sel, ALU_func, MEM_Req, MEM_WrEn, ByteOp, Illegal
  );

endinterface

// File: rtl/multicycle_control_control_out_decode.sv
// Pure mapping from (state, opcode, func, ALU_zero, Mem_Ready) to the
// datapath control word.
// Ports:
//   state_i     - current FSM state (registered)
//   opc_i       - opcode (live IR in DECODE, held copy afterwards)
//   func_i      - low nibble of the held R-type function field
//   alu_zero_i  - ALU zero flag (used only in BRANCH)
//   mem_ready_i - data-memory completion (used only in MEM_WR)
//   ctrl_o      - control word
module control_out_decode
  import multicycle_control_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opc_i,
  input  logic [3:0] func_i,
  input  logic       alu_zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  opc_class_t cls_s;

  assign cls_s = opc_class(opc_i);

  // Control word per state; decode-stage selects stay valid for the whole
  // instruction so the datapath sees stable operand routing.
  always_comb begin
    ctrl_o          = '0;
    ctrl_o.rf_b_sel = (state_i != S_IFETCH) && rf_b_sel_for(opc_i);
    ctrl_o.imm_ext  = (state_i == S_IFETCH) ? IMM_SEXT : imm_ext_for(opc_i);
    case (state_i)
      S_IFETCH: begin
        ctrl_o.ir_ld = 1'b1;
      end
      S_DECODE: begin
        // Unknown opcode retires as a NOP: step PC and flag it.
        ctrl_o.illegal = (cls_s == CLS_BAD);
        ctrl_o.pc_ld   = (cls_s == CLS_BAD);
      end
      S_EXEC_R: begin
        ctrl_o.alu_bin_sel = 1'b0;
        ctrl_o.alu_func    = func_i;
      end
      S_EXEC_I: begin
        ctrl_o.alu_bin_sel = 1'b1;
        case (opc_i)
          OPC_ANDI: ctrl_o.alu_func = ALU_AND;
          OPC_ORI:  ctrl_o.alu_func = ALU_OR;
          default:  ctrl_o.alu_func = ALU_ADD;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_bin_sel = 1'b1;
        ctrl_o.alu_func    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.byte_op = is_byte_op(opc_i);
      end
      S_MEM_WR: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_wr  = 1'b1;
        ctrl_o.byte_op = is_byte_op(opc_i);
        // A store retires in the cycle the memory accepts it.
        ctrl_o.pc_ld   = mem_ready_i;
      end
      S_WB_ALU: begin
        ctrl_o.rf_wr         = 1'b1;
        ctrl_o.rf_wrdata_sel = 1'b0;
        ctrl_o.pc_ld         = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.rf_wr         = 1'b1;
        ctrl_o.rf_wrdata_sel = 1'b1;
        ctrl_o.pc_ld         = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_bin_sel = 1'b0;
        ctrl_o.alu_func    = ALU_SUB;
        ctrl_o.pc_ld       = 1'b1;
        ctrl_o.pc_sel      = (opc_i == OPC_BEQ) ? alu_zero_i : ~alu_zero_i;
      end
      S_JUMP: begin
        ctrl_o.pc_ld  = 1'b1;
        ctrl_o.pc_sel = 1'b1;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 32-bit datapath.
// Walks IFETCH -> DECODE -> EXEC/MEM/BRANCH/JUMP -> WB and emits every
// datapath strobe through the control bus interface.
// Ports:
//   Clk   - system clock, rising edge
//   Reset - asynchronous, active-low reset
//   dp    - control bus (master side): Instr, ALU_zero, Mem_Ready in;
//           IR/PC/RF/ALU/MEM strobes and selects out
// Outputs are decoded from the registered state and the held opcode/func;
// the write strobes depend on state only. The only live-input terms are
// PC_LdEn in MEM_WR (Mem_Ready) and PC_sel in BRANCH (ALU_zero), which the
// cycle counts require to act in the same cycle.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPC_W  = OPC_W_DEF,
  parameter int FUNC_W = FUNC_W_DEF
) (
  input logic                  Clk,
  input logic                  Reset,
  multicycle_control_if.master dp
);

  state_t            state_q, state_d;
  logic [OPC_W-1:0]  opc_q, opc_d, opc_s;
  logic [FUNC_W-1:0] func_q, func_d;
  logic              run_q;
  opc_class_t        cls_s;
  ctrl_t             ctrl_s, ctrl_out_s;
  logic              unused_bits_s;

  // DECODE looks at the freshly loaded IR; later states use the held copy
  // so the IR may be reused by the datapath.
  assign opc_s = (state_q == S_DECODE) ? dp.Instr[31 -: OPC_W] : opc_q;
  assign cls_s = opc_class(opc_s);

  assign unused_bits_s = ^{dp.Instr[25:FUNC_W], func_q[FUNC_W-1:4]};

  // State, held opcode/func and run flag; reset parks in IFETCH silently.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IFETCH;
      opc_q   <= '0;
      func_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      func_q  <= func_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state and opcode-latch logic.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    func_d  = func_q;
    if (run_q) begin
      case (state_q)
        S_IFETCH: begin
          state_d = S_DECODE;
        end
        S_DECODE: begin
          opc_d  = dp.Instr[31 -: OPC_W];
          func_d = dp.Instr[FUNC_W-1:0];
          case (cls_s)
            CLS_R:     state_d = S_EXEC_R;
            CLS_ALUI:  state_d = S_EXEC_I;
            CLS_LOAD:  state_d = S_MEM_ADDR;
            CLS_STORE: state_d = S_MEM_ADDR;
            CLS_CBR:   state_d = S_BRANCH;
            CLS_JUMP:  state_d = S_JUMP;
            default:   state_d = S_IFETCH;
          endcase
        end
        S_EXEC_R:   state_d = S_WB_ALU;
        S_EXEC_I:   state_d = S_WB_ALU;
        S_MEM_ADDR: state_d = (cls_s == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   state_d = dp.Mem_Ready ? S_WB_MEM : S_MEM_RD;
        S_MEM_WR:   state_d = dp.Mem_Ready ? S_IFETCH : S_MEM_WR;
        S_WB_ALU:   state_d = S_IFETCH;
        S_WB_MEM:   state_d = S_IFETCH;
        S_BRANCH:   state_d = S_IFETCH;
        S_JUMP:     state_d = S_IFETCH;
        default:    state_d = S_IFETCH;
      endcase
    end else begin
      // First edge after reset release only arms the FSM, so IFETCH is
      // presented for a full cycle.
      state_d = state_q;
    end
  end

  control_out_decode u_decode (
    .state_i     (state_q),
    .opc_i       (opc_s[5:0]),
    .func_i      (func_q[3:0]),
    .alu_zero_i  (dp.ALU_zero),
    .mem_ready_i (dp.Mem_Ready),
    .ctrl_o      (ctrl_s)
  );

  // run_q is cleared asynchronously, so every strobe (notably MEM_Req and
  // MEM_WrEn) drops the moment Reset falls.
  assign ctrl_out_s = run_q ? ctrl_s : '0;

  assign dp.IR_LdEn       = ctrl_out_s.ir_ld;
  assign dp.PC_LdEn       = ctrl_out_s.pc_ld;
  assign dp.PC_sel        = ctrl_out_s.pc_sel;
  assign dp.RF_WrEn       = ctrl_out_s.rf_wr;
  assign dp.RF_WrData_sel = ctrl_out_s.rf_wrdata_sel;
  assign dp.RF_B_sel      = ctrl_out_s.rf_b_sel;
  assign dp.ImmExt        = ctrl_out_s.imm_ext;
  assign dp.ALU_Bin_sel   = ctrl_out_s.alu_bin_sel;
  assign dp.ALU_func      = ctrl_out_s.alu_func;
  assign dp.MEM_Req       = ctrl_out_s.mem_req;
  assign dp.MEM_WrEn      = ctrl_out_s.mem_wr;
  assign dp.ByteOp        = ctrl_out_s.byte_op;
  assign dp.Illegal       = ctrl_out_s.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver plays the datapath
// cycle by cycle and queues the expected control word for each cycle; a
// monitor on the falling edge pops and compares.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .Clk   (clk),
    .Reset (rst_n),
    .dp    (bus.master)
  );

  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;
  localparam logic [16:0] ZERO_W = 17'd0;

  logic [16:0] exp_q[$];
  string       nm_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  // Control word layout:
  // {IR, PCld, PCsel, RFwr, WDsel, Bsel, Imm[1:0], Bin, Func[3:0], Req, Wr, Byte, Ill}
  function automatic logic [16:0] cw(input logic ir, input logic pcld, input logic pcsel,
                                     input logic rfwr, input logic wdsel, input logic bsel,
                                     input logic [1:0] imm, input logic bin, input logic [3:0] fn,
                                     input logic req, input logic wr, input logic bt,
                                     input logic ill);
    return {ir, pcld, pcsel, rfwr, wdsel, bsel, imm, bin, fn, req, wr, bt, ill};
  endfunction

  // One clock cycle: drive inputs after the edge and queue the expected word.
  task automatic cyc(input logic [31:0] ins, input logic az, input logic mr,
                     input logic [16:0] e, input string nm);
    @(posedge clk);
    #1;
    bus.Instr     = ins;
    bus.ALU_zero  = az;
    bus.Mem_Ready = mr;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic fetch(input string nm);
    cyc(JUNK, 1'b1, 1'b1, cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0,
                             1'b0, 1'b0, 1'b0, 1'b0), {nm, ":fetch"});
  endtask

  task automatic t_alu(input logic [5:0] opc, input logic [5:0] fn, input logic bsel,
                       input logic [1:0] imm, input logic bin, input logic [3:0] af,
                       input string nm);
    logic [31:0] ins;
    ins = {opc, 20'hA5A5A, fn};
    fetch(nm);
    cyc(ins, 1'b1, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bsel, imm, 1'b0, 4'h0,
                            1'b0, 1'b0, 1'b0, 1'b0), {nm, ":decode"});
    cyc(JUNK, 1'b1, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bsel, imm, bin, af,
                             1'b0, 1'b0, 1'b0, 1'b0), {nm, ":exec"});
    cyc(JUNK, 1'b0, 1'b0, cw(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, bsel, imm, 1'b0, 4'h0,
                             1'b0, 1'b0, 1'b0, 1'b0), {nm, ":wb"});
  endtask

  task automatic t_load(input logic [5:0] opc, input logic bt, input int waits, input string nm);
    logic [31:0] ins;
    ins = {opc, 26'h0123456};
    fetch(nm);
    cyc(ins, 1'b0, 1'b1, ZERO_W, {nm, ":decode"});
    cyc(JUNK, 1'b0, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'h0,
                             1'b0, 1'b0, 1'b0, 1'b0), {nm, ":addr"});
    for (int i = 0; i < waits; i++)
      cyc(JUNK, 1'b0, 1'b0, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0,
                               1'b1, 1'b0, bt, 1'b0), {nm, ":wait"});
    cyc(JUNK, 1'b0, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0,
                             1'b1, 1'b0, bt, 1'b0), {nm, ":ready"});
    cyc(JUNK, 1'b0, 1'b0, cw(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'h0,
                             1'b0, 1'b0, 1'b0, 1'b0), {nm, ":wbmem"});
  endtask

  task automatic t_store(input logic [5:0] opc, input logic bt, input int waits, input string nm);
    logic [31:0] ins;
    ins = {opc, 26'h3210FED};
    fetch(nm);
    cyc(ins, 1'b0, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h0,
                            1'b0, 1'b0, 1'b0, 1'b0), {nm, ":decode"});
    cyc(JUNK, 1'b0, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 4'h0,
                             1'b0, 1'b0, 1'b0, 1'b0), {nm, ":addr"});
    for (int i = 0; i < waits; i++)
      cyc(JUNK, 1'b0, 1'b0, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h0,
                               1'b1, 1'b1, bt, 1'b0), {nm, ":wait"});
    cyc(JUNK, 1'b0, 1'b1, cw(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h0,
                             1'b1, 1'b1, bt, 1'b0), {nm, ":ready"});
  endtask

  task automatic t_branch(input logic [5:0] opc, input logic az, input logic bsel,
                          input logic [3:0] fn, input logic pcsel, input string nm);
    logic [31:0] ins;
    ins = {opc, 26'h00000F0};
    fetch(nm);
    cyc(ins, ~az, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bsel, 2'b11, 1'b0, 4'h0,
                           1'b0, 1'b0, 1'b0, 1'b0), {nm, ":decode"});
    cyc(JUNK, az, 1'b1, cw(1'b0, 1'b1, pcsel, 1'b0, 1'b0, bsel, 2'b11, 1'b0, fn,
                           1'b0, 1'b0, 1'b0, 1'b0), {nm, ":resolve"});
  endtask

  // Scoreboard monitor: compare one queued word per falling edge.
  always @(negedge clk) begin : monitor
    logic [16:0] e;
    logic [16:0] g;
    string       nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      g  = {bus.IR_LdEn, bus.PC_LdEn, bus.PC_sel, bus.RF_WrEn, bus.RF_WrData_sel,
            bus.RF_B_sel, bus.ImmExt, bus.ALU_Bin_sel, bus.ALU_func, bus.MEM_Req,
            bus.MEM_WrEn, bus.ByteOp, bus.Illegal};
      n_chk++;
      if (g === e) n_pass++;
      else $display("FAIL %s: got %b expected %b", nm, g, e);
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.Instr     = 32'h0;
    bus.ALU_zero  = 1'b0;
    bus.Mem_Ready = 1'b0;

    // Reset: silent while low, IFETCH one edge after release
    cyc(JUNK, 1'b1, 1'b1, ZERO_W, "reset0");
    cyc(JUNK, 1'b1, 1'b1, ZERO_W, "reset1");
    cyc(JUNK, 1'b0, 1'b0, ZERO_W, "release");
    rst_n = 1'b1;

    t_alu(6'b100000, 6'b110000, 1'b0, 2'b00, 1'b0, 4'b0000, "add");
    t_alu(6'b100000, 6'b010101, 1'b0, 2'b00, 1'b0, 4'b0101, "rfunc5");
    t_alu(6'b110011, 6'b000101, 1'b1, 2'b01, 1'b1, 4'b0011, "ori");
    t_alu(6'b110010, 6'b000101, 1'b1, 2'b01, 1'b1, 4'b0010, "andi");
    t_alu(6'b111001, 6'b000101, 1'b1, 2'b10, 1'b1, 4'b0000, "lui");
    t_alu(6'b111000, 6'b000101, 1'b1, 2'b00, 1'b1, 4'b0000, "li");
    t_alu(6'b110000, 6'b000101, 1'b1, 2'b00, 1'b1, 4'b0000, "addi");

    t_load(6'b001111, 1'b0, 3, "lw");
    t_load(6'b000011, 1'b1, 0, "lb");
    t_store(6'b000111, 1'b1, 1, "sb");
    t_store(6'b011111, 1'b0, 0, "sw");

    t_branch(6'b000000, 1'b1, 1'b1, 4'b0001, 1'b1, "beq_t");
    t_branch(6'b000000, 1'b0, 1'b1, 4'b0001, 1'b0, "beq_nt");
    t_branch(6'b000001, 1'b1, 1'b1, 4'b0001, 1'b0, "bne_nt");
    t_branch(6'b000001, 1'b0, 1'b1, 4'b0001, 1'b1, "bne_t");
    t_branch(6'b111111, 1'b0, 1'b0, 4'b0000, 1'b1, "b");

    // Unknown opcode: one-cycle Illegal with PC step, then IFETCH
    fetch("ill");
    cyc({6'b101010, 26'h0}, 1'b0, 1'b1, cw(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                                           4'h0, 1'b0, 1'b0, 1'b0, 1'b1), "ill:decode");
    t_alu(6'b110011, 6'b000101, 1'b1, 2'b01, 1'b1, 4'b0011, "ori_after_ill");

    // Reset asserted while a store waits on memory
    fetch("sw_rst");
    cyc({6'b011111, 26'h0}, 1'b0, 1'b0, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0,
                                           4'h0, 1'b0, 1'b0, 1'b0, 1'b0), "sw_rst:decode");
    cyc(JUNK, 1'b0, 1'b0, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 4'h0,
                             1'b0, 1'b0, 1'b0, 1'b0), "sw_rst:addr");
    cyc(JUNK, 1'b0, 1'b0, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h0,
                             1'b1, 1'b1, 1'b0, 1'b0), "sw_rst:wait");
    cyc(JUNK, 1'b0, 1'b0, ZERO_W, "sw_rst:drop");
    rst_n = 1'b0;
    cyc(JUNK, 1'b0, 1'b1, ZERO_W, "sw_rst:hold");
    cyc(JUNK, 1'b0, 1'b0, ZERO_W, "sw_rst:release");
    rst_n = 1'b1;
    t_alu(6'b100000, 6'b110000, 1'b0, 2'b00, 1'b0, 4'b0000, "add_after_rst");

    @(posedge clk);
    #6;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending words, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
